// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared state encoding, halt opcode and data width for the 8-bit CPU
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int         CPU_DW      = 8;
    localparam logic [7:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_fetch_sequencer_pc_counter.sv
`default_nettype none
// ============================================================================
// pc_counter : AW-bit program counter with load (priority) and increment
// Revision: 1.0
// ============================================================================
module pc_counter #(
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_next
);

    localparam logic [AW-1:0] ONE = AW'(1);

    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = load_val;
        end else if (inc) begin
            pc_next = pc + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_fetch_sequencer : fetch/issue controller feeding the CPU iBus
// Revision: 1.0
// ============================================================================
module cpu_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int             AW       = 8,
    parameter int             DW       = CPU_DW,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter logic [DW-1:0]  HALT_OP  = DW'(HALT_OPCODE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_load_val,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] inst,
    output logic          cpu_en,
    output logic [AW-1:0] pc,
    output logic          halted
);

    fetch_state_t  state;
    logic          abort;
    logic          load;
    logic          inc;
    logic [AW-1:0] pc_next;

    always_comb begin
        load = pc_load && (state != ST_HALT);
        inc  = (state == ST_ISSUE);
    end

    pc_counter #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .inc      (inc),
        .load_val (pc_load_val),
        .pc       (pc),
        .pc_next  (pc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            abort    <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            inst     <= '0;
            cpu_en   <= 1'b0;
            halted   <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_next;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        // A jump arrived while this word was in flight: drop it
                        // and immediately refetch from the new pc.
                        if (abort || pc_load) begin
                            abort    <= 1'b0;
                            mem_addr <= pc_next;
                        end else begin
                            inst    <= mem_rdata;
                            cpu_en  <= (mem_rdata != HALT_OP);
                            mem_req <= 1'b0;
                            state   <= ST_ISSUE;
                        end
                    end else if (pc_load) begin
                        abort <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (inst == HALT_OP) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state    <= ST_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_next;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state    <= ST_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_next;
                        halted   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_fetch_sequencer : directed vector table plus hand-written corner cases
// Revision: 1.0
// ============================================================================
module tb_cpu_fetch_sequencer;

    typedef struct packed {
        logic       start;
        logic       pc_load;
        logic [7:0] load_val;
        logic       exp_req;
        logic [7:0] exp_addr;
        logic       exp_en;
        logic [7:0] exp_inst;
        logic [7:0] exp_pc;
        logic       exp_halted;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mem [256];

    // DUT1: RESET_PC = 0, memory with programmable wait states
    logic       start1 = 1'b0, pc_load1 = 1'b0;
    logic [7:0] pc_load_val1 = 8'h00;
    logic       mem_req1, mem_ack1, cpu_en1, halted1;
    logic [7:0] mem_addr1, mem_rdata1, inst1, pc1;
    int         ws = 0;
    int         cnt1 = 0;
    logic       force_ack = 1'b0;

    // DUT2: RESET_PC = FE, zero-wait memory
    logic       start2 = 1'b0, pc_load2 = 1'b0;
    logic [7:0] pc_load_val2 = 8'h00;
    logic       mem_req2, mem_ack2, cpu_en2, halted2;
    logic [7:0] mem_addr2, mem_rdata2, inst2, pc2;

    int passed = 0;
    int total  = 0;
    vec_t vecs [27];

    always #5 clk = ~clk;

    assign mem_ack1   = (mem_req1 && (cnt1 >= ws)) || force_ack;
    assign mem_rdata1 = mem[mem_addr1];
    assign mem_ack2   = mem_req2;
    assign mem_rdata2 = mem[mem_addr2];

    always @(posedge clk) begin
        if (mem_req1 && !mem_ack1) cnt1 <= cnt1 + 1;
        else                       cnt1 <= 0;
    end

    cpu_fetch_sequencer u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .pc_load(pc_load1), .pc_load_val(pc_load_val1),
        .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_ack(mem_ack1), .mem_rdata(mem_rdata1),
        .inst(inst1), .cpu_en(cpu_en1), .pc(pc1), .halted(halted1)
    );

    cpu_fetch_sequencer #(.RESET_PC(8'hFE)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .pc_load(pc_load2), .pc_load_val(pc_load_val2),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
        .inst(inst2), .cpu_en(cpu_en2), .pc(pc2), .halted(halted2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h15; mem[8'h01] = 8'h08; mem[8'h02] = 8'h00; mem[8'h03] = 8'h09;
        mem[8'h04] = 8'h31; mem[8'h05] = 8'h0A; mem[8'h06] = 8'hFF; mem[8'h07] = 8'h11;
        mem[8'h40] = 8'h22; mem[8'h41] = 8'h77; mem[8'h50] = 8'h33; mem[8'h51] = 8'hFF;
        mem[8'hFE] = 8'hFF; mem[8'hFF] = 8'h44;

        // {start, pc_load, load_val, req, addr, cpu_en, inst, pc, halted}
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h15, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h15, 8'h01, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h08, 8'h01, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h08, 8'h02, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00, 8'h02, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 8'h00, 8'h03, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 8'h09, 8'h03, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h09, 8'h04, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h31, 8'h04, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 8'h31, 8'h05, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 8'h0A, 8'h05, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 8'h0A, 8'h06, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h06, 1'b0, 8'hFF, 8'h06, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h06, 1'b0, 8'hFF, 8'h07, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h06, 1'b0, 8'hFF, 8'h07, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h07, 1'b0, 8'hFF, 8'h07, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 8'h11, 8'h07, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h40, 1'b0, 8'h11, 8'h40, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b1, 8'h22, 8'h40, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h22, 8'h41, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 8'h50, 1'b1, 8'h50, 1'b0, 8'h22, 8'h50, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b1, 8'h33, 8'h50, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h51, 1'b0, 8'h33, 8'h51, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h51, 1'b0, 8'hFF, 8'h51, 1'b0};
        vecs[25] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h51, 1'b0, 8'hFF, 8'h52, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h51, 1'b0, 8'hFF, 8'h52, 1'b1};

        // Reset release, no start
        do_reset();
        chk("rst_req",    mem_req1, 1'b0);
        chk("rst_en",     cpu_en1,  1'b0);
        chk("rst_pc",     pc1,      8'h00);
        chk("rst_inst",   inst1,    8'h00);
        chk("rst_halted", halted1,  1'b0);
        chk("rst_pc_fe",  pc2,      8'hFE);

        // Zero-wait run, halt, resume, jumps in ISSUE and REQ
        for (int i = 0; i < 27; i++) begin
            start1       = vecs[i].start;
            pc_load1     = vecs[i].pc_load;
            pc_load_val1 = vecs[i].load_val;
            step();
            chk($sformatf("v%0d_req", i),    mem_req1,  vecs[i].exp_req);
            chk($sformatf("v%0d_addr", i),   mem_addr1, vecs[i].exp_addr);
            chk($sformatf("v%0d_en", i),     cpu_en1,   vecs[i].exp_en);
            chk($sformatf("v%0d_inst", i),   inst1,     vecs[i].exp_inst);
            chk($sformatf("v%0d_pc", i),     pc1,       vecs[i].exp_pc);
            chk($sformatf("v%0d_halted", i), halted1,   vecs[i].exp_halted);
        end
        start1 = 1'b0; pc_load1 = 1'b0; pc_load_val1 = 8'h00;

        // Three wait states, then a jump while the next request is pending
        do_reset();
        ws = 3;
        start1 = 1'b1; step(); start1 = 1'b0;
        chk("ws_req0", mem_req1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ws_req%0d", k + 1), mem_req1, 1'b1);
            chk($sformatf("ws_addr%0d", k + 1), mem_addr1, 8'h00);
            chk($sformatf("ws_en%0d", k + 1), cpu_en1, 1'b0);
        end
        step();
        chk("ws_issue_en",   cpu_en1,  1'b1);
        chk("ws_issue_inst", inst1,    8'h15);
        chk("ws_issue_req",  mem_req1, 1'b0);
        step();
        chk("ws_next_addr",  mem_addr1, 8'h01);
        pc_load1 = 1'b1; pc_load_val1 = 8'h40; step(); pc_load1 = 1'b0;
        chk("ab_pc",   pc1,       8'h40);
        chk("ab_req",  mem_req1,  1'b1);
        chk("ab_addr", mem_addr1, 8'h01);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ab_en%0d", k), cpu_en1, 1'b0);
        end
        chk("ab_refetch_addr", mem_addr1, 8'h40);
        chk("ab_refetch_req",  mem_req1,  1'b1);
        chk("ab_inst_kept",    inst1,     8'h15);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ab_wait_en%0d", k), cpu_en1, 1'b0);
        end
        step();
        chk("ab_issue_en",   cpu_en1, 1'b1);
        chk("ab_issue_inst", inst1,   8'h22);
        chk("ab_issue_pc",   pc1,     8'h40);

        // pc_load in IDLE, then asynchronous reset mid-request and a stale ack
        do_reset();
        pc_load1 = 1'b1; pc_load_val1 = 8'h30; step(); pc_load1 = 1'b0;
        chk("idle_load_pc",  pc1,      8'h30);
        chk("idle_load_req", mem_req1, 1'b0);
        start1 = 1'b1; step(); start1 = 1'b0;
        chk("ar_req_before",  mem_req1,  1'b1);
        chk("ar_addr_before", mem_addr1, 8'h30);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_req",  mem_req1,  1'b0);
        chk("ar_pc",   pc1,       8'h00);
        chk("ar_addr", mem_addr1, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        force_ack = 1'b1;
        step();
        chk("stale_en0",  cpu_en1,  1'b0);
        chk("stale_req0", mem_req1, 1'b0);
        step();
        chk("stale_en1",   cpu_en1, 1'b0);
        chk("stale_inst1", inst1,   8'h00);
        force_ack = 1'b0;

        // RESET_PC = FE: halt at FE, resume, wrap to 00
        start2 = 1'b1; step(); start2 = 1'b0;
        chk("wr_req",  mem_req2,  1'b1);
        chk("wr_addr", mem_addr2, 8'hFE);
        step();
        chk("wr_halt_inst", inst2,   8'hFF);
        chk("wr_halt_en",   cpu_en2, 1'b0);
        step();
        chk("wr_halted", halted2,  1'b1);
        chk("wr_pc_ff",  pc2,      8'hFF);
        chk("wr_hreq",   mem_req2, 1'b0);
        start2 = 1'b1; step(); start2 = 1'b0;
        chk("wr_res_req",    mem_req2,  1'b1);
        chk("wr_res_addr",   mem_addr2, 8'hFF);
        chk("wr_res_halted", halted2,   1'b0);
        step();
        chk("wr_ff_en",   cpu_en2, 1'b1);
        chk("wr_ff_inst", inst2,   8'h44);
        step();
        chk("wr_pc_00",   pc2,       8'h00);
        chk("wr_addr_00", mem_addr2, 8'h00);
        step();
        chk("wr_00_en",   cpu_en2, 1'b1);
        chk("wr_00_inst", inst2,   8'h15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
